// File: rtl/r16_mm_core.sv
// r16_mm_core: self-contained matrix-multiply test core, C = A x B on NxN
// constant ROM matrices, computed with one sequential MAC after reset release.
// Optional self-check of the result is built when R16_MM_SELFCHECK_EN is defined.
//
// Ports:
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous active-low reset
//   row_sel   in   32       result row select
//   row_data  out  N*ACCW   C[row_sel][j] at [j*ACCW +: ACCW] (combinational)
//   done      out  1        multiply complete, C stable (registered)
//   row_err   out  1        row_sel >= N (combinational)
//   pass      out  1        self-check result (0 when the checker is not built)
module r16_mm_core #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 16,
    parameter int unsigned ACCW = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       row_sel,
    output logic [N*ACCW-1:0] row_data,
    output logic              done,
    output logic              row_err,
    output logic              pass
);

    localparam int unsigned LW = $clog2(N);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned NN = N * N;
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Constant operand ROMs
    function automatic logic [DW-1:0] rom_a(input logic [LW-1:0] ri, input logic [LW-1:0] rk);
        return DW'(ri) + DW'(rk) + DW'(1);
    endfunction

    function automatic logic [DW-1:0] rom_b(input logic [LW-1:0] rk, input logic [LW-1:0] rj);
        return (rk == rj) ? DW'(2) : DW'(1);
    endfunction

    state_t            state_q, state_d;
    logic [LW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACCW-1:0]   acc_q, acc_d, acc_next;
    logic [PW-1:0]     prod;
    logic              c_we;
    logic              done_d;
    logic [ACCW-1:0]   c_mem [0:NN-1];

    // MAC datapath: accumulator restarts at k==0
    always_comb begin
        prod     = PW'(rom_a(i_q, k_q)) * PW'(rom_b(k_q, j_q));
        acc_next = ((k_q == '0) ? '0 : acc_q) + ACCW'(prod);
    end

    // State and index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            done    <= done_d;
        end
    end

    // Next-state: k innermost, then j, then i
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        c_we    = 1'b0;
        case (state_q)
            IDLE: state_d = CALC;
            CALC: begin
                acc_d = acc_next;
                if (k_q == LAST) begin
                    k_d  = '0;
                    c_we = 1'b1;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + LW'(1);
                        end
                    end else begin
                        j_d = j_q + LW'(1);
                    end
                end else begin
                    k_d = k_q + LW'(1);
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // Result storage, row-major {i,j}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NN; e++) c_mem[e] <= '0;
        end else if (c_we) begin
            c_mem[{i_q, j_q}] <= acc_next;
        end
    end

    // Row readout; any bit above the index range flags an error
    always_comb begin
        row_err  = |row_sel[31:LW];
        row_data = '0;
        if (!row_err) begin
            for (int j = 0; j < N; j++)
                row_data[j*ACCW +: ACCW] = c_mem[{row_sel[LW-1:0], LW'(j)}];
        end
    end

`ifdef R16_MM_SELFCHECK_EN
    localparam int unsigned CW = 2 * LW + 1;

    function automatic logic [ACCW-1:0] golden(input logic [LW-1:0] gi, input logic [LW-1:0] gj);
        logic [ACCW-1:0] s;
        s = '0;
        for (int gk = 0; gk < N; gk++)
            s = s + ACCW'(PW'(rom_a(gi, LW'(gk))) * PW'(rom_b(LW'(gk), gj)));
        return s;
    endfunction

    logic [CW-1:0] chk_idx;
    logic          chk_fail;
    logic          chk_match;

    always_comb begin
        chk_match = (c_mem[chk_idx[2*LW-1:0]] ==
                     golden(chk_idx[2*LW-1:LW], chk_idx[LW-1:0]));
    end

    // One element per cycle once DONE; pass rises with the last matching element
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_idx  <= '0;
            chk_fail <= 1'b0;
            pass     <= 1'b0;
        end else if (state_q == DONE && chk_idx < CW'(NN)) begin
            chk_idx <= chk_idx + CW'(1);
            if (!chk_match) chk_fail <= 1'b1;
            if (chk_idx == CW'(NN - 1)) pass <= !chk_fail && chk_match;
        end
    end
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_r16_mm_core.sv
// Directed bench for r16_mm_core: reset state, done latency, row readout,
// out-of-range select, mid-computation reset and the pass flag.
module tb_r16_mm_core;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned ACCW = 40;

    logic              clk;
    logic              reset;
    logic [31:0]       row_sel;
    logic [N*ACCW-1:0] row_data;
    logic              done;
    logic              row_err;
    logic              pass;

    int vectors;
    int miscompares;

    r16_mm_core #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk      (clk),
        .reset    (reset),
        .row_sel  (row_sel),
        .row_data (row_data),
        .done     (done),
        .row_err  (row_err),
        .pass     (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset   = 1'b0;
        row_sel = 32'd0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        vectors++;
        if (pass !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pass: got %b want 0", pass);
        end
        vectors++;
        if (row_data !== '0) begin
            miscompares++;
            $display("FAIL reset_row_data: got %h want 0", row_data);
        end
        vectors++;
        if (row_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_row_err: got %b want 0", row_err);
        end
        reset = 1'b1;
    endtask

    // Counts edges after release: done low through 64, high from 65
    task automatic test_latency(input string tag);
        logic [ACCW-1:0] e0, e1;
        for (int n = 1; n <= 65; n++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done !== (n >= 65)) begin
                miscompares++;
                $display("FAIL %s_done_edge%0d: got %b want %b", tag, n, done, (n >= 65));
            end
            if (n == 5) begin
                e0 = row_data[0 +: ACCW];
                e1 = row_data[ACCW +: ACCW];
                vectors++;
                if (e0 !== ACCW'(11) || e1 !== '0) begin
                    miscompares++;
                    $display("FAIL %s_partial_c00: got %0d,%0d want 11,0", tag, e0, e1);
                end
            end
        end
        vectors++;
        if (row_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_row_err: got %b want 0", tag, row_err);
        end
    endtask

    task automatic test_rows(input string tag);
        logic [ACCW-1:0] got, exp;
        for (int r = 0; r < N; r++) begin
            row_sel = 32'(r);
            #1;
            for (int j = 0; j < N; j++) begin
                got = row_data[j*ACCW +: ACCW];
                exp = ACCW'(5 * r + j + 11);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL %s_c%0d%0d: got %0d want %0d", tag, r, j, got, exp);
                end
            end
        end
        row_sel = 32'd0;
    endtask

    task automatic test_row_err;
        logic [31:0] sels [2];
        sels[0] = 32'h4;
        sels[1] = 32'h8000_0000;
        for (int s = 0; s < 2; s++) begin
            row_sel = sels[s];
            #1;
            vectors++;
            if (row_err !== 1'b1 || row_data !== '0) begin
                miscompares++;
                $display("FAIL row_err_sel%h: got err=%b data=%h want err=1 data=0",
                         sels[s], row_err, row_data);
            end
        end
        row_sel = 32'd0;
        #1;
    endtask

    task automatic test_pass;
`ifdef R16_MM_SELFCHECK_EN
        int waited;
        waited = 0;
        while (pass !== 1'b1 && waited < N * N) begin
            @(posedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (pass !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_after_done: got %b want 1 within %0d cycles", pass, N * N);
        end
`else
        repeat (N * N + 2) @(posedge clk);
        #1;
        vectors++;
        if (pass !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_tied: got %b want 0", pass);
        end
`endif
    endtask

    task automatic test_midreset;
        logic [ACCW-1:0] got;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        row_sel = 32'd0;
        repeat (30) @(posedge clk);
        #1;
        vectors++;
        if (row_data[3*ACCW +: ACCW] !== ACCW'(14) || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pre: got c03=%0d done=%b want 14,0",
                     row_data[3*ACCW +: ACCW], done);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || row_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_row0: got done=%b data=%h want 0,0", done, row_data);
        end
        row_sel = 32'd1;
        #1;
        got = row_data[0 +: ACCW];
        vectors++;
        if (row_data !== '0) begin
            miscompares++;
            $display("FAIL midreset_row1: got c10=%0d data=%h want 0", got, row_data);
        end
        row_sel = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        test_latency("restart");
        test_rows("restart");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_latency("first");
        test_rows("first");
        test_row_err();
        test_pass();
        test_midreset();
        test_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
